// File: rtl/serial_add_seq.sv
// serial_add_seq
//   Bit-serial add sequencer. A single 1-bit full-adder cell is time-shared
//   over WIDTH clock edges to add two WIDTH-bit unsigned operands. This trades
//   latency for area compared with a WIDTH-wide ripple chain.
//
//   Timing: the accept edge E0 (start=1 while IDLE or DONE) captures the
//   operands. RUN edges E1..E_WIDTH each process one bit, LSB first. E_WIDTH
//   loads sum/cout and raises done for exactly one cycle. busy is high in the
//   cycles that follow E0..E_(WIDTH-1).
//
//   Configuration macro: SERIAL_ADD_SUB_EN
//     When defined, this adds a 'sub' input that is captured at E0. With
//     sub=1 the module computes a + ~b + 1 (a - b), and cout=1 means no
//     borrow. When undefined there is no 'sub' port and the module only adds.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only in IDLE/DONE (ignored while RUN)
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   sub    in   1      subtract select (only with SERIAL_ADD_SUB_EN)
//   busy   out  1      high while an operation is in progress
//   done   out  1      one-cycle pulse; sum/cout valid
//   sum    out  WIDTH  result, held until the next done
//   cout   out  1      carry out of the MSB, held with sum
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  // The result accumulator only needs WIDTH-1 bits. The MSB of the result
  // comes straight from the adder on the final edge, so it never has to be
  // stored in the accumulator.
  logic [WIDTH-2:0] acc_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] sa_next;
  logic [WIDTH-1:0] sb_next;
  logic [WIDTH-2:0] acc_next;
  logic [WIDTH-1:0] sb_load;
  logic             cin0;
  logic             fa_sum;
  logic             fa_cout;
  logic             cnt_last;

  // The shared full-adder cell works on the current LSBs and the carry flop.
  assign fa_sum  = sa_reg[0] ^ sb_reg[0] ^ carry_reg;
  assign fa_cout = (sa_reg[0] & sb_reg[0]) | (carry_reg & (sa_reg[0] ^ sb_reg[0]));

  // Operands shift right so the next bit reaches position 0. Each sum bit
  // enters at the accumulator MSB. After WIDTH-1 shifts, bit 0 of the result
  // has reached acc_reg[0].
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_opshift
      assign sa_next[gi] = sa_reg[gi+1];
      assign sb_next[gi] = sb_reg[gi+1];
    end
    for (gi = 0; gi < WIDTH - 2; gi++) begin : g_accshift
      assign acc_next[gi] = acc_reg[gi+1];
    end
  endgenerate
  assign sa_next[WIDTH-1]  = 1'b0;
  assign sb_next[WIDTH-1]  = 1'b0;
  assign acc_next[WIDTH-2] = fa_sum;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction in two's complement: invert B and set the initial carry.
  assign sb_load = sub ? ~b : b;
  assign cin0    = sub;
`else
  assign sb_load = b;
  assign cin0    = 1'b0;
`endif

  // cnt_reg holds the number of RUN edges already taken. The edge that sees
  // WIDTH-1 here is E_WIDTH.
  assign cnt_last = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            sa_reg    <= a;
            sb_reg    <= sb_load;
            carry_reg <= cin0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately not looked at here; requests in RUN are dropped.
          sa_reg    <= sa_next;
          sb_reg    <= sb_next;
          acc_reg   <= acc_next;
          carry_reg <= fa_cout;
          cnt_reg   <= cnt_reg + CNT_W'(1);
          if (cnt_last) begin
            // The final bit comes from the adder directly. Only this edge
            // writes the visible result, so partial sums are never exposed.
            sum       <= {fa_sum, acc_reg};
            cout      <= fa_cout;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= DONE;
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
